// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch sequencer
package fetch_pkg;
  localparam int WORD_BYTES    = 4;
  localparam int MAX_INSTR_LEN = 15;

  typedef logic [4:0] bcount_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN
  } state_e;
endpackage

// File: rtl/fetch_byte_queue.sv
// rtl/fetch_byte_queue.sv - shift-down byte queue: consume from the head, then append at the tail
module fetch_byte_queue
  import fetch_pkg::*;
#(
  parameter int QUEUE_BYTES = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic                     consume_i,
  input  logic [3:0]               len_i,
  input  logic                     append_i,
  input  logic [31:0]              append_data_i,
  input  logic [2:0]               append_cnt_i,
  output logic [8*QUEUE_BYTES-1:0] data_o,
  output bcount_t                  count_o
);
  localparam int QW = 8 * QUEUE_BYTES;

  logic [QW-1:0] data_q, data_d, shifted, app_word;
  bcount_t       count_q, count_d, count_s;
  logic [31:0]   mask;

  always_comb begin
    shifted = data_q;
    count_s = count_q;
    if (consume_i) begin
      shifted = data_q >> {len_i, 3'b000};
      count_s = count_q - bcount_t'(len_i);
    end
    // Bytes above the valid count stay zero, so the OR merge is safe.
    mask     = 32'hFFFF_FFFF >> {3'd4 - append_cnt_i, 3'b000};
    app_word = QW'(append_data_i & mask) << {count_s, 3'b000};
    data_d   = shifted;
    count_d  = count_s;
    if (append_i) begin
      data_d  = shifted | app_word;
      count_d = count_s + bcount_t'(append_cnt_i);
    end
    if (flush_i) begin
      data_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data_o  = data_q;
  assign count_o = count_q;
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch FSM and PC tracking feeding the x86 decoder window
// Optional FETCH_PERF_CNT_EN adds saturating word/instruction/stall counters.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          QUEUE_BYTES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  output logic                     o_mem_req,
  output logic [31:0]              o_mem_addr,
  input  logic                     i_mem_ack,
  input  logic [31:0]              i_mem_data,
  output logic                     o_win_valid,
  output logic [8*QUEUE_BYTES-1:0] o_win_data,
  output logic [4:0]               o_win_count,
  output logic [31:0]              o_win_pc,
  input  logic                     i_dec_consume,
  input  logic [3:0]               i_dec_len,
  input  logic                     i_redirect,
  input  logic [31:0]              i_redirect_pc,
  output logic                     o_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]              o_perf_words,
  output logic [31:0]              o_perf_instrs,
  output logic [31:0]              o_perf_stalls
`endif
);
  state_e      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  skip_q, skip_d;
  logic        err_q, err_d;
  bcount_t     count;
  logic        legal, accept, q_consume;

  assign legal     = i_dec_consume && (i_dec_len != 4'd0) && ({1'b0, i_dec_len} <= count);
  assign q_consume = legal && !i_redirect;
  // Acks seen in S_DRAIN belong to a withdrawn address and are dropped.
  assign accept    = (state_q == S_REQ) && i_mem_ack && !i_redirect;

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    fetch_d    = fetch_q;
    pc_d       = pc_q;
    skip_d     = skip_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if ((QUEUE_BYTES - int'(count)) >= WORD_BYTES) begin
          state_d    = S_REQ;
          req_addr_d = fetch_q;
        end
      end
      S_REQ: begin
        if (i_mem_ack) begin
          state_d = S_IDLE;
          fetch_d = fetch_q + 32'd4;
          skip_d  = 2'd0;
        end
      end
      S_DRAIN: begin
        if (i_mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (q_consume) pc_d = pc_q + 32'(i_dec_len);
    if (i_dec_consume && !legal && !i_redirect) err_d = 1'b1;
    if (i_redirect) begin
      pc_d    = i_redirect_pc;
      fetch_d = {i_redirect_pc[31:2], 2'b00};
      skip_d  = i_redirect_pc[1:0];
      if (o_mem_req && !i_mem_ack) begin
        state_d = S_DRAIN;
      end else begin
        state_d    = S_IDLE;
        req_addr_d = {i_redirect_pc[31:2], 2'b00};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      req_addr_q <= {RESET_PC[31:2], 2'b00};
      fetch_q    <= {RESET_PC[31:2], 2'b00};
      pc_q       <= RESET_PC;
      skip_q     <= RESET_PC[1:0];
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      fetch_q    <= fetch_d;
      pc_q       <= pc_d;
      skip_q     <= skip_d;
      err_q      <= err_d;
    end
  end

  fetch_byte_queue #(
    .QUEUE_BYTES(QUEUE_BYTES)
  ) u_queue (
    .clk_i        (i_clk),
    .reset_i      (i_reset),
    .flush_i      (i_redirect),
    .consume_i    (q_consume),
    .len_i        (i_dec_len),
    .append_i     (accept),
    .append_data_i(i_mem_data >> {skip_q, 3'b000}),
    .append_cnt_i (3'd4 - {1'b0, skip_q}),
    .data_o       (o_win_data),
    .count_o      (count)
  );

  assign o_mem_req   = (state_q != S_IDLE);
  assign o_mem_addr  = req_addr_q;
  assign o_win_count = count;
  assign o_win_valid = (count != '0);
  assign o_win_pc    = pc_q;
  assign o_err       = err_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] words_q, instrs_q, stalls_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      words_q  <= '0;
      instrs_q <= '0;
      stalls_q <= '0;
    end else begin
      if (accept && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
      if (q_consume && (instrs_q != 32'hFFFF_FFFF)) instrs_q <= instrs_q + 32'd1;
      if ((count == '0) && !i_redirect && (stalls_q != 32'hFFFF_FFFF)) stalls_q <= stalls_q + 32'd1;
    end
  end

  assign o_perf_words  = words_q;
  assign o_perf_instrs = instrs_q;
  assign o_perf_stalls = stalls_q;
`endif
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences instruction bytes into the x86 decoder stage.
- Issues aligned 32-bit memory reads and buffers the returned bytes in a little-endian byte queue.
- Presents the queue head to the decoder as a window with a byte count and the PC of the first byte, then retires bytes when the decoder reports an instruction length.
- Handles control-flow redirects by flushing the queue and discarding any in-flight read data.

Parameters:
- QUEUE_BYTES, 16, byte-queue capacity; must be a multiple of 4 and at least 8.
- RESET_PC, 32'h0000_0000, fetch address after reset; any byte alignment is allowed.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- o_mem_req  out  1  read request; held until acknowledged.
- o_mem_addr  out  32  word-aligned read address; bits [1:0] are always 0.
- i_mem_ack  in  1  read data valid; only legal while o_mem_req=1.
- i_mem_data  in  32  read data; byte 0 is bits [7:0].
- o_win_valid  out  1  high when o_win_count is nonzero.
- o_win_data  out  8*QUEUE_BYTES  queue contents; head byte is bits [7:0]; bytes above o_win_count are zero.
- o_win_count  out  5  number of valid bytes in the queue.
- o_win_pc  out  32  address of the head byte.
- i_dec_consume  in  1  decoder retires i_dec_len bytes this cycle.
- i_dec_len  in  4  instruction length, 1..15.
- i_redirect  in  1  flush and restart fetch at i_redirect_pc.
- i_redirect_pc  in  32  new fetch PC; any alignment.
- o_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (synchronous, active-high) drives:
  - o_mem_req=0, o_mem_addr=RESET_PC&~3.
  - Queue empty: o_win_count=0, o_win_valid=0, o_win_data=0.
  - o_win_pc=RESET_PC, o_err=0, state S_IDLE.
  - Internal skip count = RESET_PC[1:0].
- FSM states:
  - S_IDLE: if free space (QUEUE_BYTES - count) is at least 4, go to S_REQ and raise o_mem_req the next cycle.
  - S_REQ: o_mem_req=1 with o_mem_addr stable.
    - On i_mem_ack, append bytes skip..3 of i_mem_data at the queue tail.
    - Then set skip=0, advance fetch address by 4, return to S_IDLE.
  - S_DRAIN: entered when a redirect arrives while o_mem_req=1.
    - o_mem_req stays 1, because the address cannot be withdrawn.
    - The next ack's data is discarded; then go to S_IDLE with the redirect address already loaded.
- Throughput: one read outstanding at most.
  - S_IDLE to request takes 1 cycle.
  - Data is visible in the window the cycle after the ack.
- Consume:
  - When i_dec_consume=1 and i_dec_len <= count: shift the queue down by i_dec_len bytes, add i_dec_len to o_win_pc, subtract it from count.
  - When i_dec_len=0 or i_dec_len > count: ignore the consume and set o_err=1.
- Consume and ack in the same cycle:
  - Apply the shift first, then append at the post-shift tail.
  - count_next = count - len + (4 - skip).
  - Space check uses pre-shift count, so overflow is impossible.
- Redirect has priority over consume and ack in the same cycle.
  - Queue is flushed, count=0.
  - o_win_pc=i_redirect_pc; fetch address = i_redirect_pc&~3; skip = i_redirect_pc[1:0].
  - An ack arriving in the redirect cycle is discarded.
  - State goes to S_DRAIN if o_mem_req=1 without an ack in the redirect cycle, otherwise S_IDLE.
- Wrap-around: fetch address and o_win_pc wrap modulo 2^32 with no flag.
- Mid-operation reset: an outstanding request is dropped immediately (o_mem_req=0 the next cycle). The memory model must tolerate this.
- o_err clears only on reset.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds 32-bit outputs o_perf_words, o_perf_instrs and o_perf_stalls.
  - o_perf_words counts accepted acks, excluding discarded ones.
  - o_perf_instrs counts legal consumes.
  - o_perf_stalls counts cycles with o_win_count=0 and no redirect.
  - All three reset to 0 and saturate at all-ones.
- FETCH_PERF_CNT_EN undefined: those ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - State enum (S_IDLE, S_REQ, S_DRAIN).
  - WORD_BYTES=4, MAX_INSTR_LEN=15.
  - Byte-count typedef (5 bits).
- One sub-module, fetch_byte_queue: shift-down byte queue with append-at-tail, consume count, flush, and count output.
- FSM and PC logic stay in fetch_sequencer.

Test Plan:
- Reset with RESET_PC=0x1000; memory returns 0x0301C001 then 0x00000000 → window 01 C0 01 03 (count 4, pc 0x1000); after consume len 2, pc=0x1002 and count is 2 plus any newly fetched bytes.
- RESET_PC=0x1003 → first read at addr 0x1000; only byte 3 is queued; count=1; o_win_pc=0x1003.
- Decoder never consumes → requests stop once count reaches 16 (exactly 4 acks from an aligned start); consume len 4 → exactly one new request issued.
- Consume len 3 and ack in the same cycle with count=8 → count=9; byte order is preserved across the boundary.
- Redirect to 0x2002 while a request is pending → next ack's data is discarded; next request addr=0x2000; queue holds bytes 2..3 only; o_win_pc=0x2002.
- Consume len 5 with count=3 → queue unchanged, o_err=1 and held until reset.
